// File: rtl/mario_pkg.sv
// -----------------------------------------------------------------------------
// mario_pkg
// Shared types and constants for the Mario sprite renderer.
//   pose_t      : animation pose chosen once per video frame
//   FRAME_*     : sprite ROM frame numbers (rom_addr[10:8])
//   KEY_A/KEY_D : keycodes for walk left / walk right
//   SPRITE_W    : sprite edge in pixels (ROM addressing assumes 16)
//   frame_sel() : maps pose + walk phase onto a ROM frame number
// -----------------------------------------------------------------------------
package mario_pkg;

  typedef enum logic [1:0] {
    POSE_IDLE = 2'd0,
    POSE_WALK = 2'd1,
    POSE_JUMP = 2'd2
  } pose_t;

  localparam logic [2:0] FRAME_IDLE  = 3'd0;
  localparam logic [2:0] FRAME_WALK0 = 3'd1;
  localparam logic [2:0] FRAME_JUMP  = 3'd4;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int SPRITE_W = 16;

  // Walk frames are consecutive starting at FRAME_WALK0; frames 5..7 are unused.
  function automatic logic [2:0] frame_sel(input pose_t pose, input logic [1:0] phase);
    case (pose)
      POSE_WALK: frame_sel = FRAME_WALK0 + {1'b0, phase};
      POSE_JUMP: frame_sel = FRAME_JUMP;
      default:   frame_sel = FRAME_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mario_sprite_renderer_if.sv
// -----------------------------------------------------------------------------
// mario_sprite_renderer_if
// Pixel-side bus of the sprite renderer: sprite ROM address/data and the
// results handed to the color mapper.
//   rom_addr    : sprite ROM address {frame[2:0], row[3:0], col[3:0]}
//   rom_data    : ROM palette index, valid one clk_50 after rom_addr
//   sprite_on   : current pixel is opaque Mario
//   sprite_idx  : palette index for the color mapper
//   facing_left : current facing direction
// Modports: master = renderer, slave = ROM / color-mapper side.
// -----------------------------------------------------------------------------
interface mario_sprite_renderer_if;

  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic        sprite_on;
  logic [3:0]  sprite_idx;
  logic        facing_left;

  modport master (
    output rom_addr,
    output sprite_on,
    output sprite_idx,
    output facing_left,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  sprite_on,
    input  sprite_idx,
    input  facing_left,
    output rom_data
  );

endinterface

// File: rtl/mario_sprite_renderer_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings a slow, asynchronous level signal into the clk_50 domain through a
// 2-flop synchronizer and emits a single-cycle pulse on each rising edge.
//   clk_50     : system clock
//   Reset      : asynchronous active-low reset
//   async_in   : level to synchronize (never used as a clock)
//   rise_pulse : one clk_50 cycle high per rising edge of async_in
// -----------------------------------------------------------------------------
module sync_edge_detect (
  input  logic clk_50,
  input  logic Reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: flops are written with <= so every register samples the values
  // present before the edge; blocking '=' here would collapse the chain.
  always_ff @(posedge clk_50 or negedge Reset) begin
    if (!Reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/mario_sprite_renderer.sv
// -----------------------------------------------------------------------------
// mario_sprite_renderer
// Chooses Mario's pose and facing once per video frame and, per pixel, fetches
// the 16x16 4bpp sprite ROM to produce a palette index and an opaque flag.
// Ports:
//   clk_50          : system clock, the only clock
//   Reset           : asynchronous active-low reset
//   frame_clk       : vsync-rate level, synchronized and edge-detected
//   pixel_clk       : pixel-rate level, synchronized and edge-detected
//   keycode         : current keyboard code (sampled on frame ticks only)
//   BallX / BallY   : Mario top-left position
//   DrawX / DrawY   : current scan position
//   bus (master)    : rom_addr/rom_data, sprite_on, sprite_idx, facing_left
// Optional build macro SPRITE_DEBUG_BOX_EN: draws the 16x16 box border in
// palette index 4'hF, overriding transparency, with unchanged latency.
// Pipeline: pix_ce -> rom_addr (+1) -> rom_data (+2) -> sprite_on/idx (+3).
// -----------------------------------------------------------------------------
module mario_sprite_renderer
  import mario_pkg::*;
#(
  parameter int         SPRITE_SIZE     = SPRITE_W,
  parameter int         ANIM_DIV        = 4,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0,
  parameter logic [7:0] KEY_LEFT        = KEY_A,
  parameter logic [7:0] KEY_RIGHT       = KEY_D
) (
  input  logic                    clk_50,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    pixel_clk,
  input  logic [7:0]              keycode,
  input  logic [9:0]              BallX,
  input  logic [9:0]              BallY,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  mario_sprite_renderer_if.master bus
);

  logic frame_tick;
  logic pix_ce;

  sync_edge_detect u_frame_sync (
    .clk_50     (clk_50),
    .Reset      (Reset),
    .async_in   (frame_clk),
    .rise_pulse (frame_tick)
  );

  sync_edge_detect u_pixel_sync (
    .clk_50     (clk_50),
    .Reset      (Reset),
    .async_in   (pixel_clk),
    .rise_pulse (pix_ce)
  );

  // ---------------------------------------------------------------------------
  // Per-frame state: pose FSM, facing, walk sequencing, previous BallY
  // ---------------------------------------------------------------------------
  pose_t      pose_q, pose_d;
  logic       facing_q, facing_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] div_q, div_d;
  logic [9:0] prev_y_q, prev_y_d;

  always_ff @(posedge clk_50 or negedge Reset) begin
    if (!Reset) begin
      pose_q   <= POSE_IDLE;
      facing_q <= 1'b0;
      phase_q  <= 2'd0;
      div_q    <= 4'd0;
      prev_y_q <= 10'd0;
    end else begin
      pose_q   <= pose_d;
      facing_q <= facing_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      prev_y_q <= prev_y_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold value first, so paths that
    // skip an assignment cannot infer a latch.
    pose_d   = pose_q;
    facing_d = facing_q;
    phase_d  = phase_q;
    div_d    = div_q;
    prev_y_d = prev_y_q;

    if (frame_tick) begin
      prev_y_d = BallY;

      // Vertical motion wins over walking: any BallY change shows the jump pose.
      if (BallY != prev_y_q)
        pose_d = POSE_JUMP;
      else if (keycode == KEY_LEFT || keycode == KEY_RIGHT)
        pose_d = POSE_WALK;
      else
        pose_d = POSE_IDLE;

      if (keycode == KEY_LEFT)
        facing_d = 1'b1;
      else if (keycode == KEY_RIGHT)
        facing_d = 1'b0;

      if (pose_d == POSE_WALK) begin
        if (div_q == 4'(ANIM_DIV - 1)) begin
          div_d   = 4'd0;
          phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        end else begin
          div_d = div_q + 4'd1;
        end
      end else begin
        div_d   = 4'd0;
        phase_d = 2'd0;
      end
    end
  end

  logic [2:0] frame;
  assign frame = frame_sel(pose_q, phase_q);

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  // 11-bit differences: a scan position left of / above Mario becomes a large
  // unsigned value and falls out of the box, and BallX near the right edge
  // cannot wrap.
  logic [10:0] dx, dy;
  logic        in_box;
  logic [3:0]  col;

  assign dx     = {1'b0, DrawX} - {1'b0, BallX};
  assign dy     = {1'b0, DrawY} - {1'b0, BallY};
  assign in_box = (dx < 11'(SPRITE_SIZE)) && (dy < 11'(SPRITE_SIZE));
  assign col    = facing_q ? (4'd15 - dx[3:0]) : dx[3:0];

  logic [10:0] rom_addr_q;
  logic        in_box_q, in_box_d;
  logic        pix_v0, pix_v1;
  logic        sprite_on_q;
  logic [3:0]  sprite_idx_q;

`ifdef SPRITE_DEBUG_BOX_EN
  logic border;
  logic border_q, border_d;

  assign border = in_box && (dx[3:0] == 4'd0 || dx[3:0] == 4'd15 ||
                             dy[3:0] == 4'd0 || dy[3:0] == 4'd15);

  always_ff @(posedge clk_50 or negedge Reset) begin
    if (!Reset) begin
      border_q <= 1'b0;
      border_d <= 1'b0;
    end else begin
      border_d <= border_q;
      if (pix_ce)
        border_q <= border;
    end
  end
`endif

  // NOTE: the data registers are reset along with the valid bits so that the
  // outputs read 0 the moment Reset asserts, even mid-line.
  always_ff @(posedge clk_50 or negedge Reset) begin
    if (!Reset) begin
      rom_addr_q   <= 11'd0;
      in_box_q     <= 1'b0;
      in_box_d     <= 1'b0;
      pix_v0       <= 1'b0;
      pix_v1       <= 1'b0;
      sprite_on_q  <= 1'b0;
      sprite_idx_q <= 4'd0;
    end else begin
      pix_v0   <= pix_ce;
      pix_v1   <= pix_v0;
      in_box_d <= in_box_q;

      // Stage 0: frame/facing come from the registered state, so a frame tick
      // in the same cycle only affects the following pixel.
      if (pix_ce) begin
        rom_addr_q <= {frame, dy[3:0], col};
        in_box_q   <= in_box;
      end

      // Stage 2: capture the ROM word once it has had a cycle to return, and
      // hold the result until the next pixel arrives.
      if (pix_v1) begin
`ifdef SPRITE_DEBUG_BOX_EN
        if (border_d) begin
          sprite_on_q  <= 1'b1;
          sprite_idx_q <= 4'hF;
        end else begin
          sprite_on_q  <= in_box_d && (bus.rom_data != TRANSPARENT_IDX);
          sprite_idx_q <= bus.rom_data;
        end
`else
        sprite_on_q  <= in_box_d && (bus.rom_data != TRANSPARENT_IDX);
        sprite_idx_q <= bus.rom_data;
`endif
      end
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.sprite_on   = sprite_on_q;
  assign bus.sprite_idx  = sprite_idx_q;
  assign bus.facing_left = facing_q;

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_mario_sprite_renderer
// Self-checking bench for mario_sprite_renderer: a fixed vector table for the
// pixel datapath, hand-written sequences for reset, facing, coincident ticks,
// walk cycling, jump and pipeline latency, then randomized frames checked
// against a behavioural model of pose/facing/pixel rules.
// -----------------------------------------------------------------------------
module tb_mario_sprite_renderer;
  import mario_pkg::*;

  localparam int ANIM_DIV = 4;

  logic       clk_50    = 1'b0;
  logic       Reset     = 1'b0;
  logic       frame_clk = 1'b0;
  logic       pixel_clk = 1'b0;
  logic [7:0] keycode   = 8'h00;
  logic [9:0] BallX     = 10'd0;
  logic [9:0] BallY     = 10'd0;
  logic [9:0] DrawX     = 10'd0;
  logic [9:0] DrawY     = 10'd0;

  mario_sprite_renderer_if bus ();

  mario_sprite_renderer #(
    .ANIM_DIV (ANIM_DIV)
  ) dut (
    .clk_50    (clk_50),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .pixel_clk (pixel_clk),
    .keycode   (keycode),
    .BallX     (BallX),
    .BallY     (BallY),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .bus       (bus)
  );

  always #5 clk_50 = ~clk_50;

  // Synchronous sprite ROM: data appears one clk_50 after the address.
  logic [3:0] rom_mem [2048];
  always @(posedge clk_50) bus.rom_data <= rom_mem[bus.rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: counts consecutive walking frames instead of tracking a
  // divider, and evaluates the pixel rules with signed integer arithmetic.
  // ---------------------------------------------------------------------------
  int    m_prev_y;
  int    m_walk_n;
  bit    m_facing;
  pose_t m_pose;

  task automatic model_reset();
    m_prev_y = 0;
    m_walk_n = 0;
    m_facing = 1'b0;
    m_pose   = POSE_IDLE;
  endtask

  task automatic model_tick();
    if (int'(BallY) != m_prev_y)               m_pose = POSE_JUMP;
    else if (keycode == 8'h04 || keycode == 8'h07) m_pose = POSE_WALK;
    else                                       m_pose = POSE_IDLE;
    m_walk_n = (m_pose == POSE_WALK) ? m_walk_n + 1 : 0;
    if (keycode == 8'h04) m_facing = 1'b1;
    else if (keycode == 8'h07) m_facing = 1'b0;
    m_prev_y = int'(BallY);
  endtask

  function automatic int m_frame();
    case (m_pose)
      POSE_WALK: return 1 + ((m_walk_n / ANIM_DIV) % 3);
      POSE_JUMP: return 4;
      default:   return 0;
    endcase
  endfunction

  task automatic model_pixel(output logic [10:0] addr, output logic on, output logic [3:0] idx);
    int dx, dy, col;
    bit inb;
    dx   = int'(DrawX) - int'(BallX);
    dy   = int'(DrawY) - int'(BallY);
    inb  = (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16);
    col  = m_facing ? 15 - (dx & 15) : (dx & 15);
    addr = 11'(m_frame() * 256 + (dy & 15) * 16 + col);
    idx  = rom_mem[addr];
    on   = inb && (idx != 4'h0);
`ifdef SPRITE_DEBUG_BOX_EN
    if (inb && (dx == 0 || dx == 15 || dy == 0 || dy == 15)) begin
      on  = 1'b1;
      idx = 4'hF;
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic frame_tick_step();
    frame_clk = 1'b1;
    repeat (4) @(negedge clk_50);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk_50);
    model_tick();
  endtask

  task automatic pixel_step();
    pixel_clk = 1'b1;
    repeat (4) @(negedge clk_50);
    pixel_clk = 1'b0;
    repeat (4) @(negedge clk_50);
  endtask

  task automatic check_pixel(input string tag);
    logic [10:0] e_addr;
    logic        e_on;
    logic [3:0]  e_idx;
    model_pixel(e_addr, e_on, e_idx);
    check({tag, " rom_addr"},    32'(bus.rom_addr),    32'(e_addr));
    check({tag, " sprite_on"},   32'(bus.sprite_on),   32'(e_on));
    check({tag, " sprite_idx"},  32'(bus.sprite_idx),  32'(e_idx));
    check({tag, " facing_left"}, 32'(bus.facing_left), 32'(m_facing));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: pixel datapath with pose IDLE, facing right
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [9:0]  bx, by, drx, dry;
    logic [3:0]  rom_val;
    logic [10:0] exp_addr;
    logic        exp_on;
    logic [3:0]  exp_idx;
    logic        border;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_frames [12];
    logic eo;
    logic [3:0] ei;

    vecs[0] = '{10'd100, 10'd200, 10'd103, 10'd205, 4'h7, 11'h053, 1'b1, 4'h7, 1'b0};
    vecs[1] = '{10'd100, 10'd200, 10'd103, 10'd205, 4'h0, 11'h053, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{10'd630, 10'd200, 10'd5,   10'd205, 4'h9, 11'h05F, 1'b0, 4'h9, 1'b0};
    vecs[3] = '{10'd630, 10'd200, 10'd639, 10'd205, 4'h3, 11'h059, 1'b1, 4'h3, 1'b0};
    vecs[4] = '{10'd100, 10'd200, 10'd115, 10'd215, 4'h2, 11'h0FF, 1'b1, 4'h2, 1'b1};
    vecs[5] = '{10'd100, 10'd200, 10'd116, 10'd205, 4'h5, 11'h050, 1'b0, 4'h5, 1'b0};
    vecs[6] = '{10'd100, 10'd200, 10'd103, 10'd199, 4'h4, 11'h0F3, 1'b0, 4'h4, 1'b0};
    vecs[7] = '{10'd100, 10'd200, 10'd100, 10'd207, 4'h0, 11'h070, 1'b0, 4'h0, 1'b1};

    exp_frames = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};

    for (int i = 0; i < 2048; i++) rom_mem[i] = 4'($urandom);

    // Reset state
    model_reset();
    repeat (3) @(negedge clk_50);
    check("reset rom_addr",    32'(bus.rom_addr),    32'h0);
    check("reset sprite_on",   32'(bus.sprite_on),   32'h0);
    check("reset sprite_idx",  32'(bus.sprite_idx),  32'h0);
    check("reset facing_left", 32'(bus.facing_left), 32'h0);
    Reset = 1'b1;
    repeat (2) @(negedge clk_50);

    // Settle into IDLE: first tick sees BallY move away from the reset prev_y.
    BallX = 10'd100; BallY = 10'd200; keycode = 8'h00;
    DrawX = 10'd103; DrawY = 10'd205;
    frame_tick_step();
    pixel_step();
    check("first tick jump frame", 32'(bus.rom_addr[10:8]), 32'd4);
    frame_tick_step();
    pixel_step();
    check("idle frame", 32'(bus.rom_addr[10:8]), 32'd0);
    check_pixel("idle pixel");

    // Table-driven datapath vectors
    for (int i = 0; i < 8; i++) begin
      BallX = vecs[i].bx; BallY = vecs[i].by;
      DrawX = vecs[i].drx; DrawY = vecs[i].dry;
      if (i == 2) begin
        // BallX moved; keep pose IDLE by ticking with BallY unchanged.
        frame_tick_step();
      end
      rom_mem[vecs[i].exp_addr] = vecs[i].rom_val;
      pixel_step();
      eo = vecs[i].exp_on;
      ei = vecs[i].exp_idx;
`ifdef SPRITE_DEBUG_BOX_EN
      if (vecs[i].border) begin eo = 1'b1; ei = 4'hF; end
`endif
      check($sformatf("vec%0d rom_addr", i),   32'(bus.rom_addr),   32'(vecs[i].exp_addr));
      check($sformatf("vec%0d sprite_on", i),  32'(bus.sprite_on),  32'(eo));
      check($sformatf("vec%0d sprite_idx", i), 32'(bus.sprite_idx), 32'(ei));
    end

    // Reset asserted mid-line clears the outputs without waiting for an edge.
    BallX = 10'd100; BallY = 10'd200; DrawX = 10'd105; DrawY = 10'd205;
    rom_mem[11'h055] = 4'h6;
    pixel_step();
    check("pre-reset sprite_on", 32'(bus.sprite_on), 32'h1);
    @(negedge clk_50);
    #2 Reset = 1'b0;
    #1;
    check("async reset sprite_on",  32'(bus.sprite_on),  32'h0);
    check("async reset rom_addr",   32'(bus.rom_addr),   32'h0);
    check("async reset sprite_idx", 32'(bus.sprite_idx), 32'h0);
    @(negedge clk_50);
    @(negedge clk_50);
    Reset = 1'b1;
    model_reset();
    frame_tick_step();
    frame_tick_step();
    DrawX = 10'd103;
    pixel_step();
    check("post-reset idle frame", 32'(bus.rom_addr[10:8]), 32'd0);

    // Facing left, then release the key: IDLE frame, mirrored column.
    keycode = 8'h04;
    frame_tick_step();
    check("facing_left after KEY_LEFT", 32'(bus.facing_left), 32'h1);
    keycode = 8'h00;
    frame_tick_step();
    pixel_step();
    check("mirrored rom_addr", 32'(bus.rom_addr), 32'h05C);
    check("mirrored col",      32'(bus.rom_addr[3:0]), 32'd12);
    check_pixel("mirrored pixel");

    // Pixel and frame tick in the same cycle: pixel sees the old facing/frame.
    keycode   = 8'h07;
    pixel_clk = 1'b1;
    frame_clk = 1'b1;
    repeat (4) @(negedge clk_50);
    pixel_clk = 1'b0;
    frame_clk = 1'b0;
    repeat (4) @(negedge clk_50);
    check("coincident uses old state", 32'(bus.rom_addr), 32'h05C);
    model_tick();
    check("coincident facing updated", 32'(bus.facing_left), 32'h0);
    pixel_step();
    check("next pixel new state", 32'(bus.rom_addr), 32'h153);
    check_pixel("post-coincident pixel");

    // Walk cycle from IDLE with KEY_RIGHT held.
    keycode = 8'h00;
    frame_tick_step();
    keycode = 8'h07;
    for (int k = 0; k < 12; k++) begin
      frame_tick_step();
      pixel_step();
      check($sformatf("walk tick%0d frame", k + 1), 32'(bus.rom_addr[10:8]), 32'(exp_frames[k]));
    end

    // BallY moves: jump; then steady again restarts the walk at phase 0.
    BallY = 10'd201; DrawY = 10'd206;
    frame_tick_step();
    pixel_step();
    check("jump frame", 32'(bus.rom_addr[10:8]), 32'd4);
    frame_tick_step();
    pixel_step();
    check("walk restart phase 0", 32'(bus.rom_addr[10:8]), 32'd1);

    // Pipeline latency: rom_addr 3 edges, result 5 edges after pixel_clk rises.
    keycode = 8'h00;
    frame_tick_step();
    DrawX = 10'd300;
    pixel_step();
    check("latency pre rom_addr", 32'(bus.rom_addr), 32'h058);
    DrawX = 10'd104;
    rom_mem[11'h054] = 4'hA;
    pixel_clk = 1'b1;
    repeat (2) @(posedge clk_50);
    #1 check("latency addr edge2", 32'(bus.rom_addr), 32'h058);
    @(posedge clk_50);
    #1 check("latency addr edge3", 32'(bus.rom_addr), 32'h054);
    @(posedge clk_50);
    #1 check("latency on edge4", 32'(bus.sprite_on), 32'h0);
    @(posedge clk_50);
    #1 check("latency on edge5", 32'(bus.sprite_on), 32'h1);
    check("latency idx edge5", 32'(bus.sprite_idx), 32'hA);
    @(negedge clk_50);
    pixel_clk = 1'b0;
    repeat (4) @(negedge clk_50);

    // Randomized frames against the model.
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 3))
        0:       keycode = 8'h00;
        1:       keycode = 8'h04;
        2:       keycode = 8'h07;
        default: keycode = 8'($urandom);
      endcase
      if ($urandom_range(0, 2) == 0) BallY = 10'($urandom_range(0, 479));
      BallX = 10'($urandom_range(0, 639));
      frame_tick_step();
      for (int p = 0; p < 3; p++) begin
        DrawX = 10'((int'(BallX) + $urandom_range(0, 21) - 3) & 1023);
        DrawY = 10'((int'(BallY) + $urandom_range(0, 21) - 3) & 1023);
        pixel_step();
        check_pixel($sformatf("rand f%0d p%0d", f, p));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
